// File: rtl/div_unit_pkg.sv
// Shared constants and types for the sequential signed divider.
package div_unit_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Magnitude of a two's complement operand, widened so that |-2^31| is representable.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
    magnitude = neg ? (-{x[WIDTH-1], x}) : {1'b0, x};
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Control-unit <-> divider handshake and operand/result bus.
// Div_Unsigned exists only when DIV_UNSIGNED_EN is defined.
interface div_unit_if #(
  parameter int unsigned WIDTH = div_unit_pkg::WIDTH
);

  logic             DivInit;
  logic [WIDTH-1:0] A_In;
  logic [WIDTH-1:0] B_In;
`ifdef DIV_UNSIGNED_EN
  logic             Div_Unsigned;
`endif
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivStop;
  logic             DivZero;
  logic             Div_Busy;

  modport master (
    output DivInit, A_In, B_In,
`ifdef DIV_UNSIGNED_EN
    output Div_Unsigned,
`endif
    input  Hi, Lo, DivStop, DivZero, Div_Busy
  );

  modport slave (
    input  DivInit, A_In, B_In,
`ifdef DIV_UNSIGNED_EN
    input  Div_Unsigned,
`endif
    output Hi, Lo, DivStop, DivZero, Div_Busy
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0] r,
  input  logic           dividend_msb,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] next_r,
  output logic           q_bit
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {r[WIDTH-1:0], dividend_msb};
    q_bit   = 1'b0;
    next_r  = shifted;
    if (shifted >= divisor) begin
      q_bit  = 1'b1;
      next_r = shifted - divisor;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit signed divider (radix-2 restoring on magnitudes, then sign fix).
// Define DIV_UNSIGNED_EN to add the Div_Unsigned input for DIVU semantics.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       Reset_In,
  div_unit_if.slave  bus
);

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   dvd, dvd_d;
  logic [WIDTH:0]     dvs, dvs_d;
  logic [WIDTH:0]     rem, rem_d;
  logic [WIDTH-1:0]   quo, quo_d;
  logic               sign_q, sign_q_d;
  logic               sign_r, sign_r_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               stop_d, zero_d, busy_d;

  logic [WIDTH:0]     step_r;
  logic               step_q;
  logic               uns;
  logic [WIDTH:0]     a_mag, b_mag;

`ifdef DIV_UNSIGNED_EN
  assign uns = bus.Div_Unsigned;
`else
  assign uns = 1'b0;
`endif

  assign a_mag = magnitude(bus.A_In, bus.A_In[WIDTH-1] & ~uns);
  assign b_mag = magnitude(bus.B_In, bus.B_In[WIDTH-1] & ~uns);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r            (rem),
    .dividend_msb (dvd[WIDTH-1]),
    .divisor      (dvs),
    .next_r       (step_r),
    .q_bit        (step_q)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge Reset_In) begin
    if (Reset_In) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      quo          <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      bus.Hi       <= '0;
      bus.Lo       <= '0;
      bus.DivStop  <= 1'b0;
      bus.DivZero  <= 1'b0;
      bus.Div_Busy <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      dvd          <= dvd_d;
      dvs          <= dvs_d;
      rem          <= rem_d;
      quo          <= quo_d;
      sign_q       <= sign_q_d;
      sign_r       <= sign_r_d;
      bus.Hi       <= hi_d;
      bus.Lo       <= lo_d;
      bus.DivStop  <= stop_d;
      bus.DivZero  <= zero_d;
      bus.Div_Busy <= busy_d;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    dvd_d    = dvd;
    dvs_d    = dvs;
    rem_d    = rem;
    quo_d    = quo;
    sign_q_d = sign_q;
    sign_r_d = sign_r;
    hi_d     = bus.Hi;
    lo_d     = bus.Lo;
    stop_d   = 1'b0;
    zero_d   = 1'b0;
    busy_d   = bus.Div_Busy;

    case (state)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.DivInit) begin
          dvd_d    = a_mag[WIDTH-1:0];
          dvs_d    = b_mag;
          rem_d    = '0;
          quo_d    = '0;
          cnt_d    = '0;
          sign_q_d = (bus.A_In[WIDTH-1] ^ bus.B_In[WIDTH-1]) & ~uns;
          sign_r_d = bus.A_In[WIDTH-1] & ~uns;
          busy_d   = 1'b1;
          // A zero divisor skips straight to DONE and leaves Hi/Lo untouched.
          if (bus.B_In == '0) begin
            state_d = S_DONE;
            stop_d  = 1'b1;
            zero_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d = step_r;
        dvd_d = {dvd[WIDTH-2:0], 1'b0};
        quo_d = {quo[WIDTH-2:0], step_q};
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ITER - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        lo_d    = sign_q ? (-quo) : quo;
        hi_d    = sign_r ? (-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
        stop_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, zero divide, reset, ignored start.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk      (clk),
    .Reset_In (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one division and check latency, results, pulse width and return to idle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_zero, input int exp_lat, input logic glitch);
    int n;
    @(negedge clk);
    bus.A_In    = a;
    bus.B_In    = b;
    bus.DivInit = 1'b1;
`ifdef DIV_UNSIGNED_EN
    bus.Div_Unsigned = uns;
`else
    if (uns) $display("note: %s requests unsigned mode, build is signed-only", tag);
`endif
    @(posedge clk);
    #1;
    bus.DivInit = 1'b0;
    bus.A_In    = 32'hDEAD_BEEF;
    bus.B_In    = 32'h0000_0003;
    check({tag, " busy"}, 32'(bus.Div_Busy), 32'd1);
    n = 0;
    while (!bus.DivStop && n < 60) begin
      if (glitch && n == 4) begin
        bus.DivInit = 1'b1;
        bus.A_In    = 32'd50;
        bus.B_In    = 32'd0;
      end
      @(posedge clk);
      #1;
      n++;
      bus.DivInit = 1'b0;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " lo"}, bus.Lo, exp_lo);
    check({tag, " hi"}, bus.Hi, exp_hi);
    check({tag, " zero"}, 32'(bus.DivZero), 32'(exp_zero));
    @(posedge clk);
    #1;
    check({tag, " stop pulse"}, 32'(bus.DivStop), 32'd0);
    check({tag, " idle"}, 32'(bus.Div_Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    bus.DivInit = 1'b0;
    bus.A_In    = '0;
    bus.B_In    = '0;
`ifdef DIV_UNSIGNED_EN
    bus.Div_Unsigned = 1'b0;
`endif
    #12;
    check("reset hi", bus.Hi, 32'd0);
    check("reset lo", bus.Lo, 32'd0);
    check("reset stop", 32'(bus.DivStop), 32'd0);
    check("reset zero", 32'(bus.DivZero), 32'd0);
    check("reset busy", 32'(bus.Div_Busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("pos", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b0);
    run_div("divzero", 32'd5, 32'd0, 1'b0, 32'd14, 32'd2, 1'b1, 0, 1'b0);
    run_div("neg_a", 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
    run_div("neg_b", 32'd100, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 32'd2, 1'b0, 33, 1'b0);
    run_div("neg_ab", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 32'd14, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);

    // Abort a running division with an asynchronous reset mid-cycle.
    @(negedge clk);
    bus.A_In    = 32'd1000;
    bus.B_In    = 32'd9;
    bus.DivInit = 1'b1;
    @(posedge clk);
    #1;
    bus.DivInit = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort hi", bus.Hi, 32'd0);
    check("abort lo", bus.Lo, 32'd0);
    check("abort stop", 32'(bus.DivStop), 32'd0);
    check("abort busy", 32'(bus.Div_Busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.DivStop) seen = 1;
    end
    check("abort no stop", 32'(seen), 32'd0);

    run_div("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b0);
    run_div("zero_dvd", 32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 33, 1'b0);
    run_div("ignored_start", 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 1'b0, 33, 1'b1);

`ifdef DIV_UNSIGNED_EN
    run_div("divu", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 33, 1'b0);
    run_div("div_m1_by_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
